// File: rtl/matrix_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : matrix_stream_reader
// Description : Requests one refresh from the random matrix generator over the
//               update_en/update_done handshake, snapshots the flat matrix bus
//               and streams the row*col valid elements row-major over a
//               valid/ready interface towards the display/UART formatter.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_stream_reader #(
  parameter int WIDTH          = 8,
  parameter int MAX_DIM        = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [2:0]                       row,
  input  logic [2:0]                       col,
  output logic                             gen_update_en,
  input  logic                             gen_update_done,
  input  logic [MAX_DIM*MAX_DIM*WIDTH-1:0] gen_matrix_flat,
  output logic [WIDTH-1:0]                 out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [2:0]                       out_row_idx,
  output logic [2:0]                       out_col_idx,
  output logic                             out_row_last,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             timeout_err
);

  localparam int c_NEL   = MAX_DIM * MAX_DIM;
  localparam int c_K_W   = $clog2(c_NEL + 1);
  localparam int c_TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         c_MAX_DIM  = 3'(MAX_DIM);

  localparam logic [1:0] c_ST_IDLE   = 2'd0;
  localparam logic [1:0] c_ST_REQ    = 2'd1;
  localparam logic [1:0] c_ST_STREAM = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;

  logic [2:0]         r_rows;
  logic [2:0]         r_cols;
  logic [c_K_W-1:0]   r_total;
  logic [c_K_W-1:0]   r_k;
  logic [c_TMO_W-1:0] r_tmo;

  logic [WIDTH-1:0]   r_cap [c_NEL];
  logic [WIDTH-1:0]   r_data;
  logic [2:0]         r_row_idx;
  logic [2:0]         r_col_idx;
  logic               r_row_last;
  logic               r_last;
  logic               r_done;
  logic               r_timeout_err;

  logic [2:0]         w_r_eff;
  logic [2:0]         w_c_eff;
  logic [c_K_W-1:0]   w_total;
  logic               w_start_ok;
  logic               w_req_expired;
  logic               w_beat;
  logic [c_K_W-1:0]   w_k_nxt;
  logic               w_col_wrap;
  logic [2:0]         w_col_nxt;
  logic [2:0]         w_row_nxt;

  // Requested dimensions clamped into 1..MAX_DIM; a zero request still yields one line.
  always_comb begin
    w_r_eff = (row == 3'd0) ? 3'd1 : ((row > c_MAX_DIM) ? c_MAX_DIM : row);
    w_c_eff = (col == 3'd0) ? 3'd1 : ((col > c_MAX_DIM) ? c_MAX_DIM : col);
    w_total = c_K_W'(w_r_eff) * c_K_W'(w_c_eff);
  end

  // A start is refused while the generator still holds done from the previous handshake.
  assign w_start_ok    = (r_state == c_ST_IDLE) && start && !gen_update_done;
  assign w_req_expired = (r_state == c_ST_REQ) && !gen_update_done && (r_tmo == c_TMO_LAST);
  assign w_beat        = (r_state == c_ST_STREAM) && out_ready;

  assign w_k_nxt    = r_k + c_K_W'(1);
  assign w_col_wrap = (r_col_idx == (r_cols - 3'd1));
  assign w_col_nxt  = w_col_wrap ? 3'd0 : (r_col_idx + 3'd1);
  assign w_row_nxt  = w_col_wrap ? (r_row_idx + 3'd1) : r_row_idx;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; done from the generator wins over an expiring timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_start_ok) w_state_nxt = c_ST_REQ;
      end
      c_ST_REQ: begin
        if (gen_update_done)    w_state_nxt = c_ST_STREAM;
        else if (w_req_expired) w_state_nxt = c_ST_IDLE;
      end
      c_ST_STREAM: begin
        if (w_beat && r_last) w_state_nxt = c_ST_IDLE;
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  // State-decoded outputs: request, valid and busy follow the state register directly.
  always_comb begin
    gen_update_en = (r_state == c_ST_REQ);
    out_valid     = (r_state == c_ST_STREAM);
    busy          = (r_state != c_ST_IDLE);
  end

  // Datapath: dimension latch, timeout counter, snapshot and the registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows        <= 3'd0;
      r_cols        <= 3'd0;
      r_total       <= '0;
      r_k           <= '0;
      r_tmo         <= '0;
      r_data        <= '0;
      r_row_idx     <= 3'd0;
      r_col_idx     <= 3'd0;
      r_row_last    <= 1'b0;
      r_last        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < c_NEL; i++) r_cap[i] <= '0;
    end else begin
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_start_ok) begin
            r_rows  <= w_r_eff;
            r_cols  <= w_c_eff;
            r_total <= w_total;
            r_tmo   <= '0;
          end
        end
        c_ST_REQ: begin
          if (gen_update_done) begin
            for (int i = 0; i < c_NEL; i++) r_cap[i] <= gen_matrix_flat[i*WIDTH +: WIDTH];
            // First beat is presented straight from the bus so it is valid next cycle.
            r_data     <= gen_matrix_flat[0 +: WIDTH];
            r_k        <= '0;
            r_row_idx  <= 3'd0;
            r_col_idx  <= 3'd0;
            r_row_last <= (r_cols == 3'd1);
            r_last     <= (r_total == c_K_W'(1));
          end else if (w_req_expired) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_tmo <= r_tmo + c_TMO_W'(1);
          end
        end
        c_ST_STREAM: begin
          if (w_beat) begin
            if (r_last) begin
              // Leave the beat fields cleared so nothing stale lingers once valid drops.
              r_done     <= 1'b1;
              r_data     <= '0;
              r_row_idx  <= 3'd0;
              r_col_idx  <= 3'd0;
              r_row_last <= 1'b0;
              r_last     <= 1'b0;
            end else begin
              r_k        <= w_k_nxt;
              r_data     <= r_cap[w_k_nxt];
              r_row_idx  <= w_row_nxt;
              r_col_idx  <= w_col_nxt;
              r_row_last <= (w_col_nxt == (r_cols - 3'd1));
              r_last     <= (w_k_nxt == (r_total - c_K_W'(1)));
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_data     = r_data;
  assign out_row_idx  = r_row_idx;
  assign out_col_idx  = r_col_idx;
  assign out_row_last = r_row_last;
  assign out_last     = r_last;
  assign done         = r_done;
  assign timeout_err  = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_matrix_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_stream_reader
// Description : Directed self-checking bench for matrix_stream_reader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_stream_reader;

  localparam int WIDTH   = 8;
  localparam int MAX_DIM = 5;
  localparam int NEL     = MAX_DIM * MAX_DIM;
  localparam int TMO     = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start;
  logic [2:0]             row;
  logic [2:0]             col;
  logic                   gen_update_en;
  logic                   gen_update_done;
  logic [NEL*WIDTH-1:0]   gen_matrix_flat;
  logic [WIDTH-1:0]       out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [2:0]             out_row_idx;
  logic [2:0]             out_col_idx;
  logic                   out_row_last;
  logic                   out_last;
  logic                   busy;
  logic                   done;
  logic                   timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  matrix_stream_reader #(
    .WIDTH          (WIDTH),
    .MAX_DIM        (MAX_DIM),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .row             (row),
    .col             (col),
    .gen_update_en   (gen_update_en),
    .gen_update_done (gen_update_done),
    .gen_matrix_flat (gen_matrix_flat),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_row_idx     (out_row_idx),
    .out_col_idx     (out_col_idx),
    .out_row_last    (out_row_last),
    .out_last        (out_last),
    .busy            (busy),
    .done            (done),
    .timeout_err     (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load(input int base);
    for (int k = 0; k < NEL; k++) gen_matrix_flat[k*WIDTH +: WIDTH] = WIDTH'(base + k);
  endtask

  // Start a request, let the generator answer after 'delay' extra REQ cycles,
  // then scramble the bus to show the snapshot is independent of it.
  task automatic request(input logic [2:0] r, input logic [2:0] c, input int delay);
    row = r; col = c; start = 1'b1;
    tick();
    start = 1'b0;
    check("req_en", 32'(gen_update_en), 32'd1);
    check("req_busy", 32'(busy), 32'd1);
    repeat (delay) tick();
    check("req_en_hold", 32'(gen_update_en), 32'd1);
    check("req_no_valid", 32'(out_valid), 32'd0);
    gen_update_done = 1'b1;
    tick();
    gen_update_done = 1'b0;
    check("cap_valid", 32'(out_valid), 32'd1);
    check("cap_en_low", 32'(gen_update_en), 32'd0);
    load(200);
  endtask

  // Expected beat i of an nr x nc matrix: data base+i, row i/nc, col i%nc.
  task automatic stream(input int nr, input int nc, input int base, input bit stall);
    int  n;
    int  i;
    int  cyc;
    bit  rdy;
    n   = nr * nc;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 300) begin
      rdy = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      out_ready = rdy;
      check("beat_valid", 32'(out_valid), 32'd1);
      check("beat_data", 32'(out_data), 32'((base + i) & 8'hFF));
      check("beat_row", 32'(out_row_idx), 32'(i / nc));
      check("beat_col", 32'(out_col_idx), 32'(i % nc));
      check("beat_row_last", 32'(out_row_last), 32'((i % nc) == nc - 1));
      check("beat_last", 32'(out_last), 32'(i == n - 1));
      check("beat_no_done", 32'(done), 32'd0);
      if (rdy) i++;
      cyc++;
      tick();
    end
    check("stream_beats", 32'(i), 32'(n));
    out_ready = 1'b0;
    check("end_done", 32'(done), 32'd1);
    check("end_valid", 32'(out_valid), 32'd0);
    check("end_busy", 32'(busy), 32'd0);
    check("end_no_tmo", 32'(timeout_err), 32'd0);
    tick();
    check("end_done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    int en_cnt;
    int tmo_cnt;
    int val_cnt;
    rst = 1'b1; start = 1'b0; row = 3'd0; col = 3'd0;
    gen_update_done = 1'b0; gen_matrix_flat = '0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_en", 32'(gen_update_en), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_tmo", 32'(timeout_err), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    rst = 1'b0;
    tick();

    // 2x3, elements k+10, generator answers late in the window.
    load(10);
    request(3'd2, 3'd3, 12);
    stream(2, 3, 10, 1'b0);

    // row=0, col=7 clamps to 1x5.
    load(8'h40);
    request(3'd0, 3'd7, 3);
    stream(1, 5, 8'h40, 1'b0);

    // 5x5 with stalls; done arrives on the very last cycle before expiry.
    load(8'hF0);
    request(3'd5, 3'd5, TMO - 1);
    stream(5, 5, 8'hF0, 1'b1);

    // Generator never answers: request held TMO cycles, one timeout pulse.
    row = 3'd2; col = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    en_cnt = 0; tmo_cnt = 0; val_cnt = 0;
    for (int t = 0; t < TMO + 10; t++) begin
      if (gen_update_en) en_cnt++;
      if (timeout_err) tmo_cnt++;
      if (out_valid) val_cnt++;
      check("tmo_no_done", 32'(done), 32'd0);
      tick();
    end
    check("tmo_en_cycles", 32'(en_cnt), 32'(TMO));
    check("tmo_pulses", 32'(tmo_cnt), 32'd1);
    check("tmo_no_valid", 32'(val_cnt), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);

    // Reset in the middle of a 3x3 stream, then a fresh full stream.
    load(8'h20);
    request(3'd3, 3'd3, 2);
    out_ready = 1'b1;
    repeat (3) tick();
    check("mid_data", 32'(out_data), 32'h23);
    check("mid_row", 32'(out_row_idx), 32'd1);
    check("mid_col", 32'(out_col_idx), 32'd0);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_en", 32'(gen_update_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    tick();
    check("rst_mid_done2", 32'(done), 32'd0);
    load(8'h30);
    request(3'd3, 3'd3, 1);
    stream(3, 3, 8'h30, 1'b0);

    // Start and new dimensions while busy are ignored: stream stays 2x2.
    load(8'h50);
    row = 3'd2; col = 3'd2; start = 1'b1;
    tick();
    row = 3'd1; col = 3'd1;
    repeat (4) tick();
    start = 1'b0;
    gen_update_done = 1'b1;
    tick();
    gen_update_done = 1'b0;
    stream(2, 2, 8'h50, 1'b0);

    // Start while done is still high in IDLE is refused until done drops.
    load(8'h60);
    gen_update_done = 1'b1;
    row = 3'd1; col = 3'd1; start = 1'b1;
    repeat (3) tick();
    check("held_done_en", 32'(gen_update_en), 32'd0);
    check("held_done_busy", 32'(busy), 32'd0);
    gen_update_done = 1'b0;
    tick();
    start = 1'b0;
    check("released_en", 32'(gen_update_en), 32'd1);
    gen_update_done = 1'b1;
    tick();
    gen_update_done = 1'b0;
    stream(1, 1, 8'h60, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
